// File: rtl/crypto_decrypt_core.sv
// +--------------------------------------------------------------------------+
// | Module   : crypto_decrypt_core                                           |
// | Purpose  : 4-round ARX block decryptor, one round per clock, with        |
// |            valid/ready handshakes. Optional abort input enabled by the   |
// |            macro CRYPTO_DECRYPT_ABORT_EN.                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module crypto_decrypt_core #(
  parameter int SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ct,
  input  logic [31:0] key,
`ifdef CRYPTO_DECRYPT_ABORT_EN
  input  logic        abort,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pt,
  output logic        busy,
  output logic [1:0]  round
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_data;
  logic [31:0] r_key;
  logic [1:0]  r_round;
  logic        w_abort;
  logic        w_hs;
  logic [31:0] w_key_rot;
  logic [31:0] w_rk;
  logic [31:0] w_sub;
  logic [31:0] w_dec;

`ifdef CRYPTO_DECRYPT_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_hs = in_valid && (r_state == c_IDLE);

  // Round key i = rotl(key, 8*i) ^ {4{i}}; byte rotations are pure rewiring.
  always_comb begin
    w_key_rot = r_key;
    case (r_round)
      2'd0: w_key_rot = r_key;
      2'd1: w_key_rot = {r_key[23:0], r_key[31:24]};
      2'd2: w_key_rot = {r_key[15:0], r_key[31:16]};
      2'd3: w_key_rot = {r_key[7:0],  r_key[31:8]};
      default: w_key_rot = r_key;
    endcase
  end

  assign w_rk  = w_key_rot ^ {4{6'd0, r_round}};
  assign w_sub = r_data - w_rk;
  assign w_dec = ((w_sub >> SHIFT) | (w_sub << (32 - SHIFT))) ^ w_rk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (in_valid) w_state_nxt = c_RUN;
      c_RUN: begin
        if (w_abort)             w_state_nxt = c_IDLE;
        else if (r_round == 2'd0) w_state_nxt = c_DONE;
      end
      c_DONE: if (w_abort || out_ready) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_IDLE);
    out_valid = (r_state == c_DONE);
    busy      = (r_state != c_IDLE);
    pt        = (r_state == c_DONE) ? r_data : 32'd0;
    round     = (r_state == c_RUN) ? r_round : 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 32'd0;
      r_key   <= 32'd0;
      r_round <= 2'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_hs) begin
            r_data  <= ct;
            r_key   <= key;
            r_round <= 2'd3;
          end
        end
        c_RUN: begin
          if (w_abort) begin
            r_data  <= 32'd0;
            r_round <= 2'd0;
          end else begin
            r_data  <= w_dec;
            r_round <= (r_round == 2'd0) ? 2'd0 : r_round - 2'd1;
          end
        end
        c_DONE: begin
          if (w_abort || out_ready) begin
            r_data <= 32'd0;
          end
        end
        default: r_round <= 2'd0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_crypto_decrypt_core.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_crypto_decrypt_core                                        |
// | Purpose  : Scoreboard bench for crypto_decrypt_core.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_crypto_decrypt_core;

  localparam int SHIFT = 3;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ct;
  logic [31:0] key;
  logic        abort_drv;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pt;
  logic        busy;
  logic [1:0]  round;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  crypto_decrypt_core #(.SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key       (key),
`ifdef CRYPTO_DECRYPT_ABORT_EN
    .abort     (abort_drv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .busy      (busy),
    .round     (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
    if (n == 0) return v;
    return (v << n) | (v >> (32 - n));
  endfunction

  // Forward cipher, used to build ciphertexts from known plaintexts.
  function automatic logic [31:0] enc(input logic [31:0] p, input logic [31:0] k);
    logic [31:0] x;
    logic [31:0] ki;
    logic [7:0]  b;
    x = p;
    for (int i = 0; i < 4; i++) begin
      b  = 8'(i);
      ki = rotl32(k, 8 * i) ^ {4{b}};
      x  = rotl32(x ^ ki, SHIFT) + ki;
    end
    return x;
  endfunction

  // Monitor: every output handshake pops one expected plaintext.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !abort_drv) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", pt, 32'hxxxxxxxx);
      end else begin
        chk("pt", pt, exp_q.pop_front());
      end
    end
  end

  // One block from IDLE through DONE; hold keeps out_ready low in DONE.
  task automatic send(input logic [31:0] c, input logic [31:0] k,
                      input logic [31:0] exp, input int hold);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(exp);
    in_valid = 1'b1;
    ct       = c;
    key      = k;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("run_out_valid", {31'd0, out_valid}, 32'd0);
      chk("run_round", {30'd0, round}, 32'(3 - i));
      chk("run_busy", {31'd0, busy}, 32'd1);
      in_valid = $urandom_range(0, 1);
      ct       = $urandom;
      key      = $urandom;
      @(posedge clk); #1;
    end
    chk("done_out_valid", {31'd0, out_valid}, 32'd1);
    chk("done_round", {30'd0, round}, 32'd0);
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        ct       = $urandom;
        @(posedge clk); #1;
        chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_pt", pt, exp);
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("after_in_ready", {31'd0, in_ready}, 32'd1);
    chk("after_out_valid", {31'd0, out_valid}, 32'd0);
    chk("after_pt", pt, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] p;
    logic [31:0] k;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    ct        = 32'd0;
    key       = 32'd0;
    abort_drv = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pt", pt, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_round", {30'd0, round}, 32'd0);
    rst_n = 1'b1;

    // Directed: zero key, 0xCDCDCDCD decrypts to zero.
    send(32'hCDCDCDCD, 32'h0, 32'h0, 0);
    // Backpressure for 10 cycles in DONE.
    send(32'hCDCDCDCD, 32'h0, 32'h0, 10);

    // Reset pulsed during round 1 discards the block.
    in_valid = 1'b1;
    ct       = 32'h12345678;
    key      = 32'h9ABCDEF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_round", {30'd0, round}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(32'hCDCDCDCD, 32'h0, 32'h0, 0);

    // Random plaintext/key round trips through the forward model.
    for (int n = 0; n < 1000; n++) begin
      p = $urandom;
      k = $urandom;
      send(enc(p, k), k, p, 0);
    end

`ifdef CRYPTO_DECRYPT_ABORT_EN
    // Abort during round 2.
    in_valid = 1'b1;
    ct       = 32'hCAFEF00D;
    key      = 32'h01020304;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_round2", {30'd0, round}, 32'd2);
    abort_drv = 1'b1;
    @(posedge clk); #1;
    abort_drv = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_round", {30'd0, round}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    // Abort together with out_ready in DONE.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_done_valid", {31'd0, out_valid}, 32'd1);
    abort_drv = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    abort_drv = 1'b0;
    chk("abort_done_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_done_pt", pt, 32'd0);
    chk("abort_done_out_valid", {31'd0, out_valid}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crypto_decrypt_core.md
CRYPTO_DECRYPT_CORE -- requirements
Module: crypto_decrypt_core

Interface
REQ-001 Parameter: SHIFT, 3, rotate amount per round (1..31).
REQ-002 The port list SHALL be: clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  ciphertext/key offered.
REQ-005 in_ready  output  1  core can accept a block.
REQ-006 ct  input  32  ciphertext word.
REQ-007 key  input  32  user key.
REQ-008 out_valid  output  1  plaintext available.
REQ-009 out_ready  input  1  consumer accepts plaintext.
REQ-010 pt  output  32  decrypted plaintext.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 round  output  2  round index being applied (3 down to 0), 0 when not in RUN.
REQ-013 One clock: clk. Reset: rst_n, asynchronous and active-low.

Function
REQ-014 Round key i (i=0..3) SHALL be K_i = rotl(key, 8*i) XOR {4{8-bit i}}, computed from the captured key.
REQ-015 The matching encryption is round i = 0..3: x = rotl(x XOR K_i, SHIFT) + K_i mod 2^32. The core SHALL be its exact inverse.
REQ-016 Decrypt round i SHALL be x = rotr(x - K_i mod 2^32, SHIFT) XOR K_i, applied for i = 3, 2, 1, 0 in that order.
REQ-017 FSM states SHALL be IDLE, RUN, DONE.
REQ-018 in_ready SHALL equal (state == IDLE). Input handshake occurs on an edge where in_valid && in_ready.
REQ-019 On the input handshake: ct and key are captured, round := 3, and the state goes IDLE->RUN.
REQ-020 In RUN: one decrypt round per clock. round decrements each cycle. After round 0, the state goes RUN->DONE.
REQ-021 out_valid SHALL be high exactly in DONE, asserting 4 clocks after the input-handshake edge.
REQ-022 pt SHALL hold the final result stable in DONE until the output handshake. pt SHALL be 0 in IDLE and RUN.
REQ-023 DONE->IDLE SHALL occur on an edge with out_ready high. out_valid may not drop without that handshake.
REQ-024 Backpressure: DONE SHALL be held indefinitely while out_ready is low.
REQ-025 No new block SHALL be accepted in RUN or DONE, and in_valid in those states SHALL be ignored. Minimum turnaround is 6 cycles per block.
REQ-026 Changes on ct and key after capture SHALL NOT affect the block in flight.
REQ-027 All arithmetic SHALL be 32-bit modulo 2^32, with rotations circular.

Reset
REQ-028 Asserting rst_n low at any time, including mid-RUN or in DONE, SHALL immediately force IDLE and discard the in-flight block.
REQ-029 Reset values: in_ready=1, out_valid=0, pt=0, busy=0, round=0, and the internal data/key registers = 0.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 and a handshake is allowed on the first rising edge.

Configuration
REQ-031 Macro CRYPTO_DECRYPT_ABORT_EN, when defined, SHALL add input abort (1 bit).
REQ-032 With CRYPTO_DECRYPT_ABORT_EN, abort high on an edge in RUN or DONE SHALL return the FSM to IDLE and clear pt, out_valid and round.
REQ-033 With CRYPTO_DECRYPT_ABORT_EN, abort has priority over a simultaneous out_ready. In IDLE, abort SHALL have no effect, and an in_valid handshake in the same cycle proceeds.
REQ-034 Without CRYPTO_DECRYPT_ABORT_EN, no abort port or logic SHALL exist, and behaviour SHALL be identical to the macro-defined build with abort held low.

Verification
REQ-035 SHIFT=3, key=0x00000000, ct=0xCDCDCDCD, out_ready=1 -> out_valid 4 cycles after handshake, pt=0x00000000.
REQ-036 Random key/plaintext, encrypted per REQ-015 in the bench model, 1000 blocks -> pt equals the original plaintext each time. round shows the sequence 3,2,1,0.
REQ-037 out_ready held low 10 cycles in DONE -> out_valid and pt=0x00000000 stable, in_ready=0, new in_valid ignored. Release -> IDLE next edge.
REQ-038 rst_n pulsed low during round 1 -> out_valid=0, in_ready=1 asynchronously. The next block (ct=0xCDCDCDCD, key=0) decrypts to 0.
REQ-039 ct/key changed every cycle during RUN -> result unaffected, matches the captured block.
REQ-040 (CRYPTO_DECRYPT_ABORT_EN) abort in round 2 -> IDLE, out_valid never rises. abort plus out_ready in DONE -> IDLE with pt cleared.
